ushift_ctrl: RTL and testbench
==============================

Name: ushift_ctrl

Overview:
- Control sequencer directly upstream of the universal shift register in the ALU shift path.
- Accepts a single shift/rotate request (op, amount) and drives the register's sel, bsLeft and bsRight lines cycle by cycle: one load cycle, then N single-bit shift cycles, then a one-cycle done pulse.
- Reads the register's current MSB and LSB so it can supply fill bits for arithmetic shifts and rotates.
- The register's data input `a` and its reset are wired separately at top level.

Parameters:
- WIDTH, 8: datapath width of the controlled shift register.
- AMT_W, 3: width of the shift amount, equal to clog2(WIDTH); maximum amount is WIDTH-1.
- SEL_LOAD, 2'b11: sel code that loads `a`.
- SEL_HOLD, 2'b00: sel code that keeps the current value.
- SEL_SHL, 2'b01: sel code that shifts toward the MSB, with bsLeft entering bit 0.
- SEL_SHR, 2'b10: sel code that shifts toward the LSB, with bsRight entering bit WIDTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request strobe; accepted only when ready=1.
- op  in  3  operation code: 000 LSL, 001 LSR, 010 ASR, 011 ROL, 100 ROR; 101-111 reserved.
- amount  in  AMT_W  number of single-bit steps.
- q_msb  in  1  a_shifted[WIDTH-1] fed back from the register.
- q_lsb  in  1  a_shifted[0] fed back from the register.
- sel  out  2  mode select to the register.
- bsLeft  out  1  serial input at bit 0 during SHL.
- bsRight  out  1  serial input at bit WIDTH-1 during SHR.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; the register holds the final result in this cycle.

Behaviour:
- FSM states: IDLE, LOAD, SHIFT, DONE. State, op_r, amt_r and cnt are registers.
- sel, bsLeft, bsRight, ready and done are combinational from state, op_r, q_msb and q_lsb.
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, op_r=0, amt_r=0.
  - Outputs: sel=SEL_HOLD, bsLeft=0, bsRight=0, ready=1, done=0.
- IDLE:
  - sel=SEL_HOLD, ready=1.
  - start=1 captures op and amount into op_r/amt_r, then goes to LOAD.
- LOAD (1 cycle):
  - sel=SEL_LOAD, so the register loads `a` at the end of this cycle.
  - cnt<=amt_r.
  - Next state is DONE if amt_r==0 or op_r is reserved, otherwise SHIFT.
- SHIFT:
  - LSL/ROL drive sel=SEL_SHL; LSR/ASR/ROR drive sel=SEL_SHR.
  - Fill bits: LSL bsLeft=0; LSR bsRight=0; ASR bsRight=q_msb; ROL bsLeft=q_msb; ROR bsRight=q_lsb.
  - The unused bs line is 0.
  - cnt decrements each cycle; when cnt==1, next state is DONE.
- DONE (1 cycle): sel=SEL_HOLD, done=1, next state IDLE.
- Latency:
  - start sampled at edge E0; LOAD occupies cycle 1; SHIFT occupies cycles 2..1+N; done asserts in cycle 2+N.
  - ready returns to 1 in cycle 3+N.
  - Back-to-back: start may be asserted in the first IDLE cycle after DONE.
- Boundaries:
  - start while ready=0 is ignored and does not disturb op_r/amt_r/cnt.
  - amount=0: LOAD then DONE, and the register equals `a`.
  - Reserved op behaves as amount=0.
  - Reset asserted mid-operation returns to IDLE immediately, with no done pulse.
  - op/amount changes after acceptance have no effect.

Optional Feature:
- Macro USHIFT_CTRL_ABORT_EN.
- When defined:
  - Adds input `abort` (1) and output `aborted` (1).
  - abort=1 in LOAD or SHIFT forces sel=SEL_HOLD in that cycle and next state DONE.
  - In that DONE cycle, done=1 and aborted=1; aborted=0 at all other times and in reset.
  - abort is ignored in IDLE and DONE.
- When undefined: neither port exists, and behaviour is exactly as above.

Test Plan:
- Bench wires ushift_ctrl to the shift register with a=8'b10110011.
- LSL 3: start, op=000, amount=3 -> sel sequence 11,01,01,01,00; done in cycle 5; a_shifted=8'b10011000.
- ASR 2 -> bsRight follows q_msb=1; done in cycle 4; a_shifted=8'b11101100. LSR 2 -> 8'b00101100.
- ROR 1 -> a_shifted=8'b11011001. ROL 4 -> a_shifted=8'b00111011. done is exactly one cycle wide in both.
- amount=0 and op=110 -> LOAD then DONE in cycle 2; a_shifted=8'b10110011; no SHL/SHR cycle.
- start re-pulsed during SHIFT of LSL 5 -> ignored, result 8'b01100000. reset=0 in cycle 3 of a second run -> sel=00, ready=1 within the same cycle, no done pulse.
- With USHIFT_CTRL_ABORT_EN, LSL 5 with abort in cycle 3 -> exactly one shift applied, a_shifted=8'b01100110; done=1 and aborted=1 in cycle 4.

Source files
------------

// File: rtl/ushift_ctrl.sv
// ushift_ctrl: control sequencer for the universal shift register in the ALU
// shift path. A request runs as one load cycle, then N single-bit shift cycles,
// then a one-cycle done pulse. The controller supplies fill bits for
// arithmetic shifts and rotates from the register's fed-back MSB/LSB.
// Optional build macro: USHIFT_CTRL_ABORT_EN adds an abort input and an
// aborted flag that is reported alongside done.
module ushift_ctrl #(
  parameter int          WIDTH    = 8,
  parameter int          AMT_W    = 3,
  parameter logic [1:0]  SEL_LOAD = 2'b11,
  parameter logic [1:0]  SEL_HOLD = 2'b00,
  parameter logic [1:0]  SEL_SHL  = 2'b01,
  parameter logic [1:0]  SEL_SHR  = 2'b10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AMT_W-1:0] amount,
  input  logic             q_msb,
  input  logic             q_lsb,
`ifdef USHIFT_CTRL_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       sel,
  output logic             bsLeft,
  output logic             bsRight,
  output logic             ready,
  output logic             done
);

  // Operation codes; anything above OP_ROR is reserved and runs as a plain load.
  localparam logic [2:0] OP_LSL = 3'b000;
  localparam logic [2:0] OP_LSR = 3'b001;
  localparam logic [2:0] OP_ASR = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  // Largest meaningful step count; larger requests saturate to it.
  localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);
  localparam logic [AMT_W-1:0] CNT_ONE = AMT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [2:0]       op_reg;
  logic [AMT_W-1:0] amt_reg;
  logic [AMT_W-1:0] cnt_reg;
  logic             op_reserved;
  logic             abort_hit;

  assign op_reserved = (op_reg > OP_ROR);

`ifdef USHIFT_CTRL_ABORT_EN
  // Abort only has an effect while the register is being loaded or shifted.
  assign abort_hit = abort && ((state_reg == S_LOAD) || (state_reg == S_SHIFT));
`else
  assign abort_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Request capture and step counter; nothing here moves unless the FSM owns it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_reg  <= 3'b000;
      amt_reg <= '0;
      cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg  <= op;
            amt_reg <= (amount >= AMT_MAX) ? AMT_MAX : amount;
          end
        end
        S_LOAD: begin
          cnt_reg <= amt_reg;
        end
        S_SHIFT: begin
          if (!abort_hit) begin
            cnt_reg <= cnt_reg - CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef USHIFT_CTRL_ABORT_EN
  logic aborted_reg;

  // Remember whether the entry into DONE was caused by an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= abort_hit;
    end
  end

  assign aborted = (state_reg == S_DONE) && aborted_reg;
`endif

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort_hit || (amt_reg == '0) || op_reserved) begin
          state_next = S_DONE;
        end else begin
          state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (abort_hit || (cnt_reg == CNT_ONE)) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output decode: register mode select, fill bits and handshake flags.
  always_comb begin
    sel     = SEL_HOLD;
    bsLeft  = 1'b0;
    bsRight = 1'b0;
    ready   = (state_reg == S_IDLE);
    done    = (state_reg == S_DONE);
    case (state_reg)
      S_LOAD: begin
        if (!abort_hit) begin
          sel = SEL_LOAD;
        end
      end
      S_SHIFT: begin
        if (!abort_hit) begin
          case (op_reg)
            OP_LSL: begin
              sel    = SEL_SHL;
              bsLeft = 1'b0;
            end
            OP_ROL: begin
              sel    = SEL_SHL;
              bsLeft = q_msb;
            end
            OP_LSR: begin
              sel     = SEL_SHR;
              bsRight = 1'b0;
            end
            OP_ASR: begin
              sel     = SEL_SHR;
              bsRight = q_msb;
            end
            OP_ROR: begin
              sel     = SEL_SHR;
              bsRight = q_lsb;
            end
            default: begin
              sel = SEL_HOLD;
            end
          endcase
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ushift_ctrl.sv
// Testbench for ushift_ctrl: wires the controller to a behavioural 8-bit
// universal shift register and checks sel sequences, done timing and the
// resulting register value against an arithmetic reference model.
module tb_ushift_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] op;
  logic [2:0] amount;
  logic       q_msb;
  logic       q_lsb;
  logic [1:0] sel;
  logic       bsLeft;
  logic       bsRight;
  logic       ready;
  logic       done;
  logic       abort;
  logic       aborted;
  logic [7:0] a_in;
  logic [7:0] q;

  int checks = 0;
  int errors = 0;

  ushift_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .amount  (amount),
    .q_msb   (q_msb),
    .q_lsb   (q_lsb),
`ifdef USHIFT_CTRL_ABORT_EN
    .abort   (abort),
    .aborted (aborted),
`endif
    .sel     (sel),
    .bsLeft  (bsLeft),
    .bsRight (bsRight),
    .ready   (ready),
    .done    (done)
  );

`ifndef USHIFT_CTRL_ABORT_EN
  assign aborted = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controlled universal shift register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 8'h00;
    else begin
      case (sel)
        2'b11:   q <= a_in;
        2'b01:   q <= {q[6:0], bsLeft};
        2'b10:   q <= {bsRight, q[7:1]};
        default: q <= q;
      endcase
    end
  end
  assign q_msb = q[7];
  assign q_lsb = q[0];

  // Reference result computed directly from the operation definitions.
  function automatic logic [7:0] ref_result(input logic [2:0] o, input int n, input logic [7:0] av);
    logic [15:0] dbl;
    dbl = {av, av};
    case (o)
      3'd0: return av << n;
      3'd1: return av >> n;
      3'd2: return 8'($signed(av) >>> n);
      3'd3: begin dbl = dbl << n; return dbl[15:8]; end
      3'd4: begin dbl = dbl >> n; return dbl[7:0]; end
      default: return av;
    endcase
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge and check every cycle until ready returns.
  // repulse>0 re-asserts start (with a different op/amount) in that cycle.
  task automatic run_op(input logic [2:0] o, input int n, input logic [7:0] av, input int repulse);
    int         eff;
    logic [1:0] shift_sel;
    logic [7:0] exp_q;
    string      nm;
    eff       = (o > 3'd4) ? 0 : n;
    shift_sel = ((o == 3'd0) || (o == 3'd3)) ? 2'b01 : 2'b10;
    exp_q     = ref_result(o, eff, av);
    nm        = $sformatf("op%0d_n%0d", o, n);
    a_in   = av;
    op     = o;
    amount = 3'(n);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = 3'($urandom_range(0, 7));
    amount = 3'($urandom_range(0, 7));
    for (int c = 1; c <= eff + 3; c++) begin
      @(negedge clk);
      start = (c == repulse);
      if (c == repulse) begin
        op     = 3'd3;
        amount = 3'd1;
      end
      if (c == 1) begin
        check($sformatf("%s c%0d load_sel", nm, c), {6'd0, sel}, 8'd3);
        check($sformatf("%s c%0d busy", nm, c), {6'd0, ready, done}, 8'd0);
      end else if (c <= eff + 1) begin
        check($sformatf("%s c%0d shift_sel", nm, c), {6'd0, sel}, {6'd0, shift_sel});
        check($sformatf("%s c%0d unused_bs", nm, c), {7'd0, (shift_sel == 2'b01) ? bsRight : bsLeft}, 8'd0);
        check($sformatf("%s c%0d busy", nm, c), {6'd0, ready, done}, 8'd0);
      end else if (c == eff + 2) begin
        check($sformatf("%s c%0d done", nm, c), {5'd0, done, ready, aborted}, 8'b100);
        check($sformatf("%s c%0d hold_sel", nm, c), {6'd0, sel}, 8'd0);
        check($sformatf("%s c%0d result", nm, c), q, exp_q);
      end else begin
        check($sformatf("%s c%0d idle", nm, c), {6'd0, done, ready}, 8'b01);
        check($sformatf("%s c%0d result_held", nm, c), q, exp_q);
      end
    end
    $display("op=%0d amount=%0d a=%02h -> q=%02h (model %02h)", o, n, av, q, exp_q);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    amount = 3'd0;
    abort  = 1'b0;
    a_in   = 8'b10110011;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_outputs", {2'b00, sel, bsLeft, bsRight, ready, done}, 8'b0000_0010);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", {6'd0, ready, done}, 8'b10);

    // Directed cases from the plan.
    run_op(3'd0, 3, 8'b10110011, 0);
    run_op(3'd2, 2, 8'b10110011, 0);
    run_op(3'd1, 2, 8'b10110011, 0);
    run_op(3'd4, 1, 8'b10110011, 0);
    run_op(3'd3, 4, 8'b10110011, 0);
    run_op(3'd0, 0, 8'b10110011, 0);
    run_op(3'd6, 5, 8'b10110011, 0);
    run_op(3'd0, 5, 8'b10110011, 3);
    check("lsl5_repulse_value", q, 8'b01100000);

    // Reset in cycle 3 of a run: immediate IDLE, no done pulse.
    a_in = 8'b10110011; op = 3'd0; amount = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_outputs", {3'd0, sel, ready, done, bsLeft}, 8'b0000_0100);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("midreset_nodone%0d", c), {6'd0, ready, done}, 8'b10);
    end
    reset = 1'b1;
    @(negedge clk);
    run_op(3'd4, 7, 8'b01011100, 0);

`ifdef USHIFT_CTRL_ABORT_EN
    // LSL 5 aborted in cycle 3: one shift applied.
    a_in = 8'b10110011; op = 3'd0; amount = 3'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_hold_sel", {6'd0, sel}, 8'd0);
    @(negedge clk);
    abort = 1'b0;
    check("abort_done_flags", {6'd0, done, aborted}, 8'b11);
    check("abort_result", q, 8'b01100110);
    @(negedge clk);
    check("abort_after", {5'd0, ready, done, aborted}, 8'b100);
`endif

    // Randomized back-to-back requests.
    for (int i = 0; i < 24; i++) begin
      run_op(3'($urandom_range(0, 7)), $urandom_range(0, 7), 8'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
